cpu_divide: RTL

- Iterative 32-bit integer divider for the RV32M DIV/DIVU/REM/REMU group. It is the inverse datapath to the CPU multiply unit and sits beside it in the execute stage.
- Radix-2 restoring algorithm, one quotient bit per clock.
- Quotient and remainder are produced together, and a done pulse is raised.
- The execute stage stalls on o_busy and selects quotient or remainder itself.

---
 rtl/cpu_divide.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/cpu_divide.sv
// -----------------------------------------------------------------------------
// cpu_divide
//   Iterative radix-2 restoring divider for the RV32M DIV/DIVU/REM/REMU group.
//   One quotient bit is produced per clock. Quotient and remainder are
//   produced together and announced with a single-cycle o_done pulse. The
//   execute stage stalls on o_busy and picks quotient or remainder itself.
//
//   Optional build macro: CPU_DIVIDE_FAST_PATH_EN
//     When defined, divide-by-zero, signed overflow and |op1| < |op2| finish
//     on the start edge: results and o_done are registered on that edge and
//     o_busy is never raised. When undefined, every operation takes the full
//     iterative path and the special cases are resolved in FINISH. Result
//     values are the same in both builds.
//
// Ports
//   i_clock      in   clock, all state changes on the rising edge
//   i_reset_n    in   asynchronous active-low reset
//   i_latch      in   start pulse, only sampled in IDLE
//   i_signed     in   1 = DIV/REM, 0 = DIVU/REMU
//   i_op1        in   dividend
//   i_op2        in   divisor
//   o_busy       out  high while a division is in progress
//   o_done       out  one-cycle pulse when results become valid
//   o_quotient   out  quotient, held until the next completion
//   o_remainder  out  remainder, held until the next completion
// -----------------------------------------------------------------------------
module cpu_divide #(
   parameter int WIDTH = 32
) (
   input  logic             i_clock,
   input  logic             i_reset_n,
   input  logic             i_latch,
   input  logic             i_signed,
   input  logic [WIDTH-1:0] i_op1,
   input  logic [WIDTH-1:0] i_op2,
   output logic             o_busy,
   output logic             o_done,
   output logic [WIDTH-1:0] o_quotient,
   output logic [WIDTH-1:0] o_remainder
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      FINISH = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [WIDTH-1:0] quotient_q, quotient_d;
   logic [WIDTH-1:0] remainder_q, remainder_d;
   logic [WIDTH-1:0] part_rem_q, part_rem_d;   // partial remainder
   logic [WIDTH-1:0] dvd_q, dvd_d;             // |dividend|, quotient bits shift in at the bottom
   logic [WIDTH-1:0] dvs_q, dvs_d;             // |divisor|
   logic             s1_q, s1_d;
   logic             s2_q, s2_d;
   logic             div_zero_q, div_zero_d;
   logic [CW-1:0]    count_q, count_d;

   // Operand capture helpers
   logic             s1_in, s2_in;
   logic [WIDTH-1:0] mag1_in, mag2_in;

   assign s1_in   = i_signed & i_op1[WIDTH-1];
   assign s2_in   = i_signed & i_op2[WIDTH-1];
   assign mag1_in = s1_in ? -i_op1 : i_op1;
   assign mag2_in = s2_in ? -i_op2 : i_op2;

   // One restoring step. The shifted remainder needs an extra bit because
   // 2*rem+1 can exceed WIDTH bits when the divisor is large.
   logic [WIDTH:0] shifted;
   logic [WIDTH:0] diff;
   logic           no_borrow;

   assign shifted   = {part_rem_q, dvd_q[WIDTH-1]};
   assign diff      = shifted - {1'b0, dvs_q};
   assign no_borrow = ~diff[WIDTH];

`ifdef CPU_DIVIDE_FAST_PATH_EN
   logic             fast_zero, fast_ovf, fast_less, fast_hit;
   logic [WIDTH-1:0] fast_quot, fast_rem;

   assign fast_zero = (i_op2 == '0);
   assign fast_ovf  = i_signed && (i_op1 == {1'b1, {(WIDTH-1){1'b0}}}) && (i_op2 == '1);
   assign fast_less = (mag1_in < mag2_in);
   assign fast_hit  = fast_zero | fast_ovf | fast_less;
   // Divide-by-zero and |op1| < |op2| both return the dividend untouched.
   assign fast_quot = fast_zero ? '1 : (fast_ovf ? {1'b1, {(WIDTH-1){1'b0}}} : '0);
   assign fast_rem  = fast_ovf ? '0 : i_op1;
`endif

   always_comb begin
      state_d     = state_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
      part_rem_d  = part_rem_q;
      dvd_d       = dvd_q;
      dvs_d       = dvs_q;
      s1_d        = s1_q;
      s2_d        = s2_q;
      div_zero_d  = div_zero_q;
      count_d     = count_q;

      case (state_q)
         IDLE: begin
            if (i_latch) begin
               s1_d       = s1_in;
               s2_d       = s2_in;
               dvd_d      = mag1_in;
               dvs_d      = mag2_in;
               part_rem_d = '0;
               count_d    = CW'(WIDTH - 1);
               div_zero_d = (i_op2 == '0);
`ifdef CPU_DIVIDE_FAST_PATH_EN
               if (fast_hit) begin
                  quotient_d  = fast_quot;
                  remainder_d = fast_rem;
                  done_d      = 1'b1;
               end else begin
                  busy_d  = 1'b1;
                  state_d = RUN;
               end
`else
               busy_d  = 1'b1;
               state_d = RUN;
`endif
            end
         end

         RUN: begin
            part_rem_d = no_borrow ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
            dvd_d      = {dvd_q[WIDTH-2:0], no_borrow};
            count_d    = count_q - 1'b1;
            if (count_q == '0) begin
               state_d = FINISH;
            end
         end

         FINISH: begin
            // A zero divisor drives every quotient bit to 1, but the sign
            // fix-up would corrupt that for negative dividends, so it is
            // forced. The remainder needs no forcing: re-applying the
            // dividend's sign to |op1| gives op1 back. Signed overflow falls
            // out of the normal arithmetic.
            quotient_d  = div_zero_q ? '1 : ((s1_q ^ s2_q) ? -dvd_q : dvd_q);
            remainder_d = s1_q ? -part_rem_q : part_rem_q;
            done_d      = 1'b1;
            busy_d      = 1'b0;
            state_d     = IDLE;
         end

         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q     <= IDLE;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         quotient_q  <= '0;
         remainder_q <= '0;
         part_rem_q  <= '0;
         dvd_q       <= '0;
         dvs_q       <= '0;
         s1_q        <= 1'b0;
         s2_q        <= 1'b0;
         div_zero_q  <= 1'b0;
         count_q     <= '0;
      end else begin
         state_q     <= state_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         quotient_q  <= quotient_d;
         remainder_q <= remainder_d;
         part_rem_q  <= part_rem_d;
         dvd_q       <= dvd_d;
         dvs_q       <= dvs_d;
         s1_q        <= s1_d;
         s2_q        <= s2_d;
         div_zero_q  <= div_zero_d;
         count_q     <= count_d;
      end
   end

   assign o_busy      = busy_q;
   assign o_done      = done_q;
   assign o_quotient  = quotient_q;
   assign o_remainder = remainder_q;

endmodule
